// File: rtl/rob_recovery_ctrl_pkg.sv
// rob_recovery_ctrl_pkg: shared types and age helper for the ROB recovery controller
package rob_recovery_ctrl_pkg;
  localparam int ROB_SZ = 8;
  localparam int IDX_W  = $clog2(ROB_SZ);
  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef enum logic [1:0] {RR_IDLE, RR_WALK, RR_UNDO} rr_state_e;
  function automatic rob_idx_t rob_age(rob_idx_t idx, rob_idx_t head);
    return idx - head;
  endfunction
endpackage

// File: rtl/rob_recovery_ctrl_age_cmp.sv
// rob_age_cmp: older_a is high when index a is strictly older than index b relative to head
module rob_age_cmp
  import rob_recovery_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0] a,
  input  logic [IDX_W-1:0] b,
  input  logic [IDX_W-1:0] head,
  output logic             older_a
);
  assign older_a = rob_age(a, head) < rob_age(b, head);
endmodule

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: grants head retirement and walks the ROB youngest-to-branch on mispredict
// Ports: clock/reset (async, active-high); mispredict_valid/index, rob_head/tail/full, head_done in;
// walk_idx out with walk_rd/T/Told read back; move_head, fl_en/fl_preg, map_en/map_areg/map_preg,
// undo/undo_index, dispatch_stall, busy out. ROB_RECOVERY_STATS_EN adds squash_cnt/recovery_cnt.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mispredict_valid,
  input  logic [IDX_W-1:0]  mispredict_index,
  input  logic [IDX_W-1:0]  rob_head,
  input  logic [IDX_W-1:0]  rob_tail,
  input  logic              rob_full,
  input  logic              head_done,
  output logic [IDX_W-1:0]  walk_idx,
  input  logic [AREG_W-1:0] walk_rd,
  input  logic [PREG_W-1:0] walk_T,
  input  logic [PREG_W-1:0] walk_Told,
  output logic              move_head,
  output logic              fl_en,
  output logic [PREG_W-1:0] fl_preg,
  output logic              map_en,
  output logic [AREG_W-1:0] map_areg,
  output logic [PREG_W-1:0] map_preg,
  output logic              undo,
  output logic [IDX_W-1:0]  undo_index,
  output logic              dispatch_stall,
`ifdef ROB_RECOVERY_STATS_EN
  output logic              busy,
  output logic [15:0]       squash_cnt,
  output logic [15:0]       recovery_cnt
`else
  output logic              busy
`endif
);
  rr_state_e state_q, state_d;
  rob_idx_t  ptr_q, ptr_d, tgt_q, tgt_d, ptr_m1, tail_m1;
  logic      newer, empty, squash;
  assign ptr_m1  = ptr_q - 1'b1;
  assign tail_m1 = rob_tail - 1'b1;
  assign empty   = rob_head == rob_tail && !rob_full;
  rob_age_cmp u_cmp (.a(mispredict_index), .b(tgt_q), .head(rob_head), .older_a(newer));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tgt_d   = tgt_q;
    if (state_q == RR_IDLE && mispredict_valid) begin
      tgt_d   = mispredict_index;
      ptr_d   = tail_m1;
      state_d = tail_m1 == mispredict_index ? RR_UNDO : RR_WALK;
    end else if (state_q == RR_WALK) begin
      // an older branch resolving mid-walk pulls the stop point further back
      tgt_d   = mispredict_valid && newer ? mispredict_index : tgt_q;
      ptr_d   = ptr_m1;
      state_d = rob_age(ptr_m1, rob_head) <= rob_age(tgt_d, rob_head) ? RR_UNDO : RR_WALK;
    end else if (state_q == RR_UNDO) begin
      state_d = RR_IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RR_IDLE;
      ptr_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
    end
  end
  // entries writing r0 own no physical register, so they are walked without writes
  assign squash         = state_q == RR_WALK && walk_rd != '0;
  assign walk_idx       = ptr_q;
  assign move_head      = state_q == RR_IDLE && head_done && !empty && !mispredict_valid;
  assign fl_en          = squash;
  assign map_en         = squash;
  assign fl_preg        = squash ? walk_T : '0;
  assign map_areg       = squash ? walk_rd : '0;
  assign map_preg       = squash ? walk_Told : '0;
  assign undo           = state_q == RR_UNDO;
  assign undo_index     = undo ? tgt_q : '0;
  assign dispatch_stall = state_q != RR_IDLE;
  assign busy           = state_q != RR_IDLE;
`ifdef ROB_RECOVERY_STATS_EN
  logic [15:0] squash_cnt_q, squash_cnt_d, recovery_cnt_q, recovery_cnt_d;
  always_comb begin
    squash_cnt_d   = squash_cnt_q + {15'd0, state_q == RR_WALK && squash_cnt_q != 16'hFFFF};
    recovery_cnt_d = recovery_cnt_q + {15'd0, state_q == RR_UNDO && recovery_cnt_q != 16'hFFFF};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      squash_cnt_q   <= '0;
      recovery_cnt_q <= '0;
    end else begin
      squash_cnt_q   <= squash_cnt_d;
      recovery_cnt_q <= recovery_cnt_d;
    end
  end
  assign squash_cnt   = squash_cnt_q;
  assign recovery_cnt = recovery_cnt_q;
`endif
endmodule
